// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_pkg
//  Description : Shared UART constants: word width, default FIFO pointer
//                width and the derived FIFO depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

  // Word width shared by the receiver, transmitter and their FIFOs.
  localparam int c_DBIT   = 8;
  // Default FIFO pointer width (address bits, without the wrap bit).
  localparam int c_ADDR_W = 4;
  // Default FIFO depth in words.
  localparam int c_DEPTH  = 2 ** c_ADDR_W;

endpackage : uart_rx_fifo_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Push/pop and status bundle between a UART FIFO and its
//                producer/consumer logic. The slave side is the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DBIT   = c_DBIT,
  parameter int ADDR_W = c_ADDR_W
);

  logic [DBIT-1:0] wr_data;
  logic            wr_en;
  logic            rd_en;
  logic            overflow_clr;
  logic [DBIT-1:0] rd_data;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;

  // Producer/consumer side: drives strobes and data, observes status.
  modport master (
    output wr_data, wr_en, rd_en, overflow_clr,
    input  rd_data, empty, full, count, overflow
  );

  // FIFO side.
  modport slave (
    input  wr_data, wr_en, rd_en, overflow_clr,
    output rd_data, empty, full, count, overflow
  );

endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_ctrl
//  Description : FIFO bookkeeping: read/write pointers with wrap bit,
//                registered occupancy, full/empty and sticky overflow.
//                Storage lives in the parent; this block only hands out
//                addresses and the write enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              i_wr_en,
  input  wire logic              i_rd_en,
  input  wire logic              i_overflow_clr,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [ADDR_W:0]        o_count,
  output logic                   o_overflow,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic                   o_wr_fire,
  output logic [ADDR_W-1:0]      o_rd_addr
);

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic [ADDR_W:0] w_wr_ptr_nxt;
  logic [ADDR_W:0] w_rd_ptr_nxt;

  // Equal pointers mean empty; same slot but opposite lap bit means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // A pop on a full FIFO frees the slot being written in the same edge.
  assign w_push = i_wr_en && (!w_full || i_rd_en);
  assign w_pop  = i_rd_en && !w_empty;
  assign w_drop = i_wr_en && w_full && !i_rd_en;

  assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop};

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      // A new drop takes priority over a clear in the same cycle.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_wr_addr  = r_wr_ptr[ADDR_W-1:0];
  assign o_wr_fire  = w_push;
  assign o_rd_addr  = r_rd_ptr[ADDR_W-1:0];

endmodule : uart_fifo_ctrl
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side show-ahead FIFO behind the UART receiver.
//                Captures a word on each done strobe, presents the head
//                word combinationally, flags dropped words as overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DBIT   = c_DBIT,
  parameter int ADDR_W = c_ADDR_W
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  uart_rx_fifo_if.slave   bus
);

  localparam int c_DEPTH_LOCAL = 2 ** ADDR_W;

  logic [DBIT-1:0]   r_mem [c_DEPTH_LOCAL];

  logic              w_empty;
  logic              w_wr_fire;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  uart_fifo_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_wr_en        (bus.wr_en),
    .i_rd_en        (bus.rd_en),
    .i_overflow_clr (bus.overflow_clr),
    .o_empty        (w_empty),
    .o_full         (bus.full),
    .o_count        (bus.count),
    .o_overflow     (bus.overflow),
    .o_wr_addr      (w_wr_addr),
    .o_wr_fire      (w_wr_fire),
    .o_rd_addr      (w_rd_addr)
  );

  // Word storage; intentionally not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[w_wr_addr] <= bus.wr_data;
    end
  end

  // Head word is forced to zero while empty so stale storage never shows.
  assign bus.rd_data = w_empty ? '0 : r_mem[w_rd_addr];
  assign bus.empty   = w_empty;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic clk;
  logic reset_n;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

  uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] nxt_val;
  int         pushes;
  int         pops;
  logic       do_push;
  logic       do_pop;

  initial begin
    reset_n          = 1'b0;
    bus.wr_data      = '0;
    bus.wr_en        = 1'b0;
    bus.rd_en        = 1'b0;
    bus.overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Reset / idle state
    check("rst_empty",    bus.empty,    1);
    check("rst_full",     bus.full,     0);
    check("rst_count",    bus.count,    0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_rd_data",  bus.rd_data,  0);

    // Single push then pop
    push(8'hA5);
    check("p1_empty", bus.empty,   0);
    check("p1_count", bus.count,   1);
    check("p1_data",  bus.rd_data, 8'hA5);
    pop();
    check("p1_pop_empty", bus.empty, 1);
    check("p1_pop_count", bus.count, 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full",  bus.full,  1);
    check("fill_count", bus.count, 16);
    push(8'hFF);
    check("ovf_flag",  bus.overflow, 1);
    check("ovf_count", bus.count,    16);
    check("ovf_head",  bus.rd_data,  8'h00);
    for (int i = 0; i < 16; i++) begin
      check("drain_data", bus.rd_data, 32'(i));
      pop();
    end
    check("drain_empty", bus.empty,    1);
    check("drain_ovf",   bus.overflow, 1);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    check("ovf_clr", bus.overflow, 0);

    // Simultaneous push/pop on a full FIFO
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    check("full2", bus.full, 1);
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 8'h77;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("fullrw_count", bus.count,    16);
    check("fullrw_ovf",   bus.overflow, 0);
    check("fullrw_head",  bus.rd_data,  8'h21);
    for (int i = 0; i < 15; i++) begin
      check("fullrw_seq", bus.rd_data, 32'(8'h21 + i));
      pop();
    end
    check("fullrw_last",  bus.rd_data, 8'h77);
    check("fullrw_cnt1",  bus.count,   1);
    pop();
    check("fullrw_empty", bus.empty, 1);

    // Simultaneous push/pop on an empty FIFO, then underflow
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("emptyrw_count", bus.count,   1);
    check("emptyrw_data",  bus.rd_data, 8'h3C);
    pop();
    pop();
    check("undf_count", bus.count,    0);
    check("undf_empty", bus.empty,    1);
    check("undf_ovf",   bus.overflow, 0);
    check("undf_full",  bus.full,     0);

    // Wrap test: 40 words through, occupancy kept within 1..15
    nxt_val = 8'h40;
    q.delete();
    push(nxt_val);
    q.push_back(nxt_val);
    nxt_val++;
    pushes = 1;
    pops   = 0;
    for (int cyc = 0; cyc < 2000 && pops < 40; cyc++) begin
      do_push = (pushes < 40) && (q.size() < 15) && ($urandom_range(0, 1) == 1);
      do_pop  = (q.size() > 0) && ((q.size() > 1) || (pushes >= 40)) &&
                ($urandom_range(0, 1) == 1);
      if (do_pop) check("wrap_data", bus.rd_data, 32'(q[0]));
      bus.wr_en   = do_push;
      bus.wr_data = nxt_val;
      bus.rd_en   = do_pop;
      tick();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      if (do_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (do_push) begin
        q.push_back(nxt_val);
        nxt_val++;
        pushes++;
      end
      check("wrap_count", bus.count, 32'(q.size()));
    end
    check("wrap_done",  pops,      40);
    check("wrap_empty", bus.empty, 1);

    // Overflow set wins over simultaneous clear
    for (int i = 0; i < 16; i++) push(8'(8'h90 + i));
    bus.wr_en        = 1'b1;
    bus.wr_data      = 8'hEE;
    bus.overflow_clr = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("setwins_ovf",   bus.overflow, 1);
    check("setwins_count", bus.count,    16);
    tick();
    bus.overflow_clr = 1'b0;
    check("clr_alone", bus.overflow, 0);
    check("clr_head",  bus.rd_data,  8'h90);

    // Asynchronous reset mid-burst with 5 words stored
    for (int i = 0; i < 16; i++) pop();
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    check("pre_rst_count", bus.count, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_empty", bus.empty,   1);
    check("async_rst_count", bus.count,   0);
    check("async_rst_data",  bus.rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_empty", bus.empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_fifo
`default_nettype wire
